// File: rtl/ee357_nx_mux_arb_if.sv
// ee357_nx_mux_arb_if: producer channels, select and consumer handshake of the registered mux/arbiter
interface ee357_nx_mux_arb_if #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2
);
    logic [N*WIDTH-1:0] in_data;
    logic [N-1:0]       in_valid;
    logic [N-1:0]       in_ready;
    logic [SELW-1:0]    sel;
    logic [WIDTH-1:0]   out_data;
    logic               out_valid;
    logic               out_ready;
    logic [SELW-1:0]    out_src;
    modport master (
        output in_data, in_valid, sel, out_ready,
        input  in_ready, out_data, out_valid, out_src
    );
    modport slave (
        input  in_data, in_valid, sel, out_ready,
        output in_ready, out_data, out_valid, out_src
    );
endinterface

// File: rtl/ee357_nx_mux_arb.sv
// ee357_nx_mux_arb: one-word registered N-way mux, channel chosen by sel (MODE 0) or round-robin (MODE 1)
module ee357_nx_mux_arb #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input logic               clk,
    input logic               rst,
    ee357_nx_mux_arb_if.slave bus
);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t           state, state_nxt;
    logic [SELW-1:0]  rr_ptr, g, idx, src_q;
    logic [WIDTH-1:0] data_q;
    logic             gv, accept, xfer;
    always_comb begin
        g   = '0;
        gv  = 1'b0;
        idx = '0;
        if (MODE == 0) begin
            g  = bus.sel;
            gv = (int'(bus.sel) < N) && bus.in_valid[bus.sel];
        end else begin
            // scan from farthest to nearest so the channel right after rr_ptr wins
            for (int k = N; k >= 1; k--) begin
                idx = SELW'((int'(rr_ptr) + k) % N);
                if (bus.in_valid[idx]) begin
                    g  = idx;
                    gv = 1'b1;
                end
            end
        end
    end
    assign accept       = (state == EMPTY) || bus.out_ready;
    assign xfer         = accept && gv;
    assign bus.in_ready = xfer ? (N'(1) << g) : '0;
    assign bus.out_valid = (state == FULL);
    assign bus.out_data  = data_q;
    assign bus.out_src   = src_q;
    always_comb begin
        state_nxt = state;
        state_nxt = xfer ? FULL : (bus.out_ready ? EMPTY : state);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= EMPTY;
            data_q <= '0;
            src_q  <= '0;
            rr_ptr <= SELW'(N - 1);
        end else begin
            state <= state_nxt;
            if (xfer) begin
                data_q <= bus.in_data[int'(g)*WIDTH +: WIDTH];
                src_q  <= g;
                if (MODE == 1) rr_ptr <= g;
            end
        end
    end
endmodule
